warp_fetch_scheduler: RTL
=========================

WARP_FETCH_SCHEDULER -- requirements
Module: warp_fetch_scheduler

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 8, number of warps; all warp vectors are NUM_WARPS wide, one bit per warpID.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Start_Warps_IF  input  8  per-warp launch request.
REQ-005 SHALL have port Stall_IF  input  1  global fetch stall (I-cache miss).
REQ-006 SHALL have port IB_Full_IF  input  8  I-buffer slot full, per warp.
REQ-007 SHALL have port BrPend_ID_IF  input  8  decoded BEQ/BLT, per warp; enters branch wait.
REQ-008 SHALL have port BrResolve_SIMT_IF  input  8  branch resolved by SIMT stack, per warp.
REQ-009 SHALL have port Exit_ID_IF  input  8  decoded EXIT, per warp.
REQ-010 SHALL have port Grant_IF0  output  8  one-hot or zero; warp fetched in slot 0.
REQ-011 SHALL have port Grant_IF1  output  8  one-hot or zero; warp fetched in slot 1; never equal to a set bit of Grant_IF0.
REQ-012 SHALL have port Active_IF  output  8  warps in ACTIVE or BRWAIT.
REQ-013 SHALL have port Done_IF  output  8  warps in DONE.

Function
REQ-014 SHALL keep a per-warp 2-bit FSM: IDLE, ACTIVE, BRWAIT, DONE.
REQ-015 Transitions: IDLE->ACTIVE on Start; ACTIVE->BRWAIT on BrPend; BRWAIT->ACTIVE on BrResolve; ACTIVE/BRWAIT->DONE on Exit; DONE->ACTIVE on Start; all other input combinations hold.
REQ-016 Priority for the same warp in the same cycle: Exit > BrPend > BrResolve > Start; Start on ACTIVE/BRWAIT ignored; Exit/BrPend/BrResolve on IDLE ignored.
REQ-017 BrPend and BrResolve together on an ACTIVE warp: the warp stays ACTIVE (resolve already available).
REQ-018 SHALL keep a per-warp 2-bit in-flight shift mask: a warp granted in cycle t is ineligible in t+1 and t+2 (covers IF->ID latency before BrPend/Exit arrive).
REQ-019 Eligible[i] = state ACTIVE, not IB_Full_IF[i], in-flight mask zero.
REQ-020 SHALL select up to two eligible warps by round-robin from pointer rr_ptr (3 bits): the first eligible index at or after rr_ptr (mod 8) -> Grant_IF0; the next distinct one -> Grant_IF1.
REQ-021 Grants SHALL be registered: selection from cycle-t state appears on outputs at t+1; Grant_IF0 empty implies Grant_IF1 empty.
REQ-022 rr_ptr SHALL advance to (index of last granted warp + 1) mod 8; unchanged when nothing is granted; wraps 7->0.
REQ-023 While Stall_IF=1: grants, rr_ptr and in-flight masks SHALL hold; warp FSMs still update.
REQ-024 A warp entering DONE or BRWAIT while its grant is held under stall SHALL have that grant cleared in the next cycle.
REQ-025 No eligible warps: both grants zero; exactly one: Grant_IF0 only.

Reset
REQ-026 On rst_n low, asynchronously: all FSMs IDLE, grants 0, in-flight masks 0, rr_ptr 0, Active_IF 0, Done_IF 0.
REQ-027 Reset asserted mid-operation SHALL discard all pending branch waits; after release no grant issues until a new Start.

Structure
REQ-028 Warp state encodings, NUM_WARPS and the in-flight depth constant (2) SHALL live in the shared GPU package.
REQ-029 The round-robin two-winner picker SHALL be one sub-module, rr_pick2 (eligible vector + pointer in, two one-hot vectors out, purely combinational).

Verification
REQ-030 Start=8'hFF, no stalls -> grants {0,1},{2,3},{4,5},{6,7}, then {0,1} in cycles 1-4 after launch and again in cycle 5 (in-flight gap respected).
REQ-031 Start=8'h01 only -> Grant_IF0=8'h01 every third cycle, Grant_IF1=0 always.
REQ-032 Warps 0-3 active, BrPend[1] at cycle 5 -> warp 1 never granted until BrResolve[1]; granted within 3 cycles after it.
REQ-033 Stall_IF high 4 cycles with grants {2,3} -> outputs hold 8'h04/8'h08 and rr_ptr holds; Exit[3] during the stall -> Grant_IF1 clears next cycle.
REQ-034 Exit and BrResolve on warp 5 in the same cycle -> Done_IF[5]=1 and Active_IF[5]=0; Start[5] later -> ACTIVE again.
REQ-035 rst_n pulsed low mid-run with warps in BRWAIT -> all outputs 0 immediately; no grants until a new Start.

Source files
------------

// File: rtl/warp_fetch_scheduler_pkg.sv
// rtl/warp_fetch_scheduler_pkg.sv - shared GPU constants, warp state encoding and warp transition function
package warp_fetch_scheduler_pkg;

  localparam int GPU_NUM_WARPS = 8;
  localparam int GPU_IF_DEPTH  = 2;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_ACTIVE = 2'd1,
    W_BRWAIT = 2'd2,
    W_DONE   = 2'd3
  } warp_state_e;

  // Exit beats BrPend beats BrResolve beats Start; a pend that arrives with its resolve never waits.
  function automatic warp_state_e warp_next(
    input warp_state_e cur,
    input logic        start,
    input logic        brpend,
    input logic        brres,
    input logic        ex
  );
    warp_state_e nxt;
    nxt = cur;
    case (cur)
      W_IDLE:   if (start) nxt = W_ACTIVE;
      W_ACTIVE: begin
        if (ex)                      nxt = W_DONE;
        else if (brpend && !brres)   nxt = W_BRWAIT;
      end
      W_BRWAIT: begin
        if (ex)                      nxt = W_DONE;
        else if (!brpend && brres)   nxt = W_ACTIVE;
      end
      W_DONE:   if (start) nxt = W_ACTIVE;
      default:  nxt = W_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/warp_fetch_scheduler_if.sv
// rtl/warp_fetch_scheduler_if.sv - fetch scheduler control/grant bundle
interface warp_fetch_scheduler_if
  import warp_fetch_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = GPU_NUM_WARPS
) ();

  logic [NUM_WARPS-1:0] Start_Warps_IF;
  logic                 Stall_IF;
  logic [NUM_WARPS-1:0] IB_Full_IF;
  logic [NUM_WARPS-1:0] BrPend_ID_IF;
  logic [NUM_WARPS-1:0] BrResolve_SIMT_IF;
  logic [NUM_WARPS-1:0] Exit_ID_IF;
  logic [NUM_WARPS-1:0] Grant_IF0;
  logic [NUM_WARPS-1:0] Grant_IF1;
  logic [NUM_WARPS-1:0] Active_IF;
  logic [NUM_WARPS-1:0] Done_IF;

  modport master (
    output Start_Warps_IF, Stall_IF, IB_Full_IF, BrPend_ID_IF, BrResolve_SIMT_IF, Exit_ID_IF,
    input  Grant_IF0, Grant_IF1, Active_IF, Done_IF
  );

  modport slave (
    input  Start_Warps_IF, Stall_IF, IB_Full_IF, BrPend_ID_IF, BrResolve_SIMT_IF, Exit_ID_IF,
    output Grant_IF0, Grant_IF1, Active_IF, Done_IF
  );

endinterface

// File: rtl/warp_fetch_scheduler_rr_pick2.sv
// rtl/warp_fetch_scheduler_rr_pick2.sv - combinational round-robin picker returning up to two one-hot winners
module rr_pick2 #(
  parameter int N  = 8,
  parameter int PW = 3
) (
  input  logic [N-1:0]  i_elig,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant0,
  output logic [N-1:0]  o_grant1
);

  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;
  logic          w_found0;
  logic          w_found1;

  always_comb begin
    o_grant0 = '0;
    o_grant1 = '0;
    w_found0 = 1'b0;
    w_found1 = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_idx = w_sum[PW-1:0];
      if (i_elig[w_idx]) begin
        if (!w_found0) begin
          o_grant0[w_idx] = 1'b1;
          w_found0        = 1'b1;
        end else if (!w_found1) begin
          o_grant1[w_idx] = 1'b1;
          w_found1        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/warp_fetch_scheduler.sv
// rtl/warp_fetch_scheduler.sv - per-warp lifecycle FSMs and dual-slot round-robin instruction fetch grants
module warp_fetch_scheduler
  import warp_fetch_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = GPU_NUM_WARPS
) (
  input logic                   clk,
  input logic                   rst_n,
  warp_fetch_scheduler_if.slave bus
);

  localparam int PW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

  warp_state_e          r_state     [NUM_WARPS];
  warp_state_e          w_state_nxt [NUM_WARPS];
  logic [NUM_WARPS-1:0] r_inflight  [GPU_IF_DEPTH];
  logic [NUM_WARPS-1:0] r_grant0;
  logic [NUM_WARPS-1:0] r_grant1;
  logic [PW-1:0]        r_rr_ptr;

  logic [NUM_WARPS-1:0] w_busy, w_elig, w_keep, w_active, w_done;
  logic [NUM_WARPS-1:0] w_pick0, w_pick1, w_hold0, w_hold1;
  logic [PW-1:0]        w_last, w_ptr_nxt;
  logic                 w_any;

  always_comb begin
    w_busy   = '0;
    w_elig   = '0;
    w_keep   = '0;
    w_active = '0;
    w_done   = '0;
    for (int d = 0; d < GPU_IF_DEPTH; d++) w_busy = w_busy | r_inflight[d];
    for (int i = 0; i < NUM_WARPS; i++) begin
      w_state_nxt[i] = warp_next(r_state[i], bus.Start_Warps_IF[i], bus.BrPend_ID_IF[i],
                                 bus.BrResolve_SIMT_IF[i], bus.Exit_ID_IF[i]);
      w_elig[i]   = (r_state[i] == W_ACTIVE) && !bus.IB_Full_IF[i] && !w_busy[i];
      w_keep[i]   = (w_state_nxt[i] == W_ACTIVE);
      w_active[i] = (r_state[i] == W_ACTIVE) || (r_state[i] == W_BRWAIT);
      w_done[i]   = (r_state[i] == W_DONE);
    end
  end

  rr_pick2 #(
    .N  (NUM_WARPS),
    .PW (PW)
  ) u_pick (
    .i_elig   (w_elig),
    .i_ptr    (r_rr_ptr),
    .o_grant0 (w_pick0),
    .o_grant1 (w_pick1)
  );

  // Held grants drop warps leaving ACTIVE; slot 1 promotes so slot 0 is never empty alone.
  always_comb begin
    w_hold0 = r_grant0 & w_keep;
    w_hold1 = r_grant1 & w_keep;
    if (w_hold0 == '0) begin
      w_hold0 = w_hold1;
      w_hold1 = '0;
    end
  end

  always_comb begin
    w_last = r_rr_ptr;
    w_any  = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (w_pick0[i]) begin
        w_last = PW'(i);
        w_any  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (w_pick1[i]) w_last = PW'(i);
    end
    if (!w_any)                               w_ptr_nxt = r_rr_ptr;
    else if (w_last == PW'(NUM_WARPS - 1))    w_ptr_nxt = '0;
    else                                      w_ptr_nxt = w_last + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WARPS; i++) r_state[i] <= W_IDLE;
      for (int d = 0; d < GPU_IF_DEPTH; d++) r_inflight[d] <= '0;
      r_grant0 <= '0;
      r_grant1 <= '0;
      r_rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) r_state[i] <= w_state_nxt[i];
      if (bus.Stall_IF) begin
        r_grant0 <= w_hold0;
        r_grant1 <= w_hold1;
      end else begin
        r_grant0      <= w_pick0;
        r_grant1      <= w_pick1;
        r_rr_ptr      <= w_ptr_nxt;
        r_inflight[0] <= w_pick0 | w_pick1;
        for (int d = 1; d < GPU_IF_DEPTH; d++) r_inflight[d] <= r_inflight[d-1];
      end
    end
  end

  assign bus.Grant_IF0 = r_grant0;
  assign bus.Grant_IF1 = r_grant1;
  assign bus.Active_IF = w_active;
  assign bus.Done_IF   = w_done;

endmodule
